// File: rtl/dma_cmd_arbiter_pkg.sv
// Shared definitions for the DMA command arbiter: FSM encoding, DMA opcodes
// and command field positions.
package dma_cmd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] DMA_OPCODE  = 8'h03;
    localparam logic [7:0] SUBOP_LOAD  = 8'h01;
    localparam logic [7:0] SUBOP_STORE = 8'h02;

    localparam int unsigned OPCODE_MSB = 127;
    localparam int unsigned OPCODE_LSB = 120;
    localparam int unsigned SUBOP_MSB  = 119;
    localparam int unsigned SUBOP_LSB  = 112;

    function automatic logic [127:0] make_cmd(input logic [7:0]   opcode,
                                              input logic [7:0]   subop,
                                              input logic [111:0] payload);
        logic [127:0] cmd;
        cmd                        = '0;
        cmd[OPCODE_MSB:OPCODE_LSB] = opcode;
        cmd[SUBOP_MSB:SUBOP_LSB]   = subop;
        cmd[SUBOP_LSB-1:0]         = payload;
        return cmd;
    endfunction

endpackage

// File: rtl/dma_cmd_arbiter_rr.sv
// Round-robin picker: first requester at or after ptr+1 (mod NUM_REQ),
// returned as a one-hot grant and a binary index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Arbitrates per-requester DMA commands onto a single DMA engine, one
// command outstanding at a time, with a watchdog on completion.
module dma_cmd_arbiter
    import dma_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CMD_WIDTH      = 128,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           req_done,
    output logic [CMD_WIDTH-1:0]         dma_cmd,
    output logic                         dma_cmd_valid,
    input  logic                         dma_cmd_ready,
    input  logic                         dma_cmd_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [WD_W-1:0]    watchdog;
    logic               do_grant;
    logic               do_accept;
    logic               do_done;
    logic               do_expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (last_grant),
        .grant (grant),
        .idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        do_grant      = 1'b0;
        do_accept     = 1'b0;
        do_done       = 1'b0;
        do_expire     = 1'b0;
        req_ready     = '0;
        dma_cmd_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (|req_valid) begin
                    do_grant   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dma_cmd_valid = 1'b1;
                if (dma_cmd_ready) begin
                    do_accept  = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Completion takes priority over a same-cycle watchdog expiry.
                if (dma_cmd_done) begin
                    do_done    = 1'b1;
                    state_next = ST_IDLE;
                end else if (watchdog == WD_LAST) begin
                    do_expire  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            dma_cmd     <= '0;
            req_done    <= '0;
            err_timeout <= 1'b0;
            watchdog    <= '0;
        end else begin
            req_done <= '0;
            if (do_grant) begin
                owner   <= grant_idx;
                dma_cmd <= req_cmd[grant_idx*CMD_WIDTH +: CMD_WIDTH];
            end
            if (do_accept) begin
                watchdog <= '0;
            end else if (state == ST_BUSY) begin
                watchdog <= watchdog + 1'b1;
            end
            if (do_done) begin
                req_done[owner] <= 1'b1;
            end
            if (do_done || do_expire) begin
                last_grant <= owner;
            end
            if (do_expire) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
